// File: rtl/ps2_kbd_capture.sv
// PS/2 keyboard receiver: sync + glitch filter, 11-bit frame FSM, 4-byte history.
// Define PS2_BREAK_FILTER_EN to keep 0xF0 and the byte after it out of kbd.
module ps2_kbd_capture #(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic        clk_100m,
  input  logic        rst,
  input  logic        ps2_clk,
  input  logic        ps2_data,
  output logic [31:0] kbd,
  output logic [7:0]  byte_out,
  output logic        byte_valid,
  output logic        parity_err,
  output logic        frame_err
);
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DATA   = 2'd1;
  localparam logic [1:0] S_PARITY = 2'd2;
  localparam logic [1:0] S_STOP   = 2'd3;

  // bit 0 carries ps2_clk, bit 1 carries ps2_data
  logic [1:0]    r_s1;
  logic [1:0]    r_s2;
  logic [1:0]    r_flt;
  logic [FW-1:0] r_fcnt [2];

  always_ff @(posedge clk_100m or posedge rst) begin
    if (rst) begin
      r_s1      <= 2'b11;
      r_s2      <= 2'b11;
      r_flt     <= 2'b11;
      r_fcnt[0] <= '0;
      r_fcnt[1] <= '0;
    end else begin
      r_s1 <= {ps2_data, ps2_clk};
      r_s2 <= r_s1;
      for (int i = 0; i < 2; i++) begin
        if (r_s2[i] == r_flt[i]) begin
          r_fcnt[i] <= '0;
        end else if (r_fcnt[i] == FW'(FILTER_LEN - 1)) begin
          r_flt[i]  <= r_s2[i];
          r_fcnt[i] <= '0;
        end else begin
          r_fcnt[i] <= r_fcnt[i] + FW'(1);
        end
      end
    end
  end

  logic          r_clk_d;
  logic [1:0]    r_state;
  logic [2:0]    r_bit;
  logic [7:0]    r_sr;
  logic          r_par;
  logic [TW-1:0] r_to;
  logic [31:0]   r_kbd;
  logic [7:0]    r_byte;
  logic          r_valid;
  logic          r_perr;
  logic          r_ferr;
`ifdef PS2_BREAK_FILTER_EN
  logic          r_brk;
`endif

  logic w_fall;
  logic w_din;
  logic w_par_ok;
  logic w_to_hit;

  assign w_fall   = r_clk_d & ~r_flt[0];
  assign w_din    = r_flt[1];
  assign w_par_ok = ^{r_sr, r_par};
  // fires one cycle early so the registered pulse lands TIMEOUT_CYC after the edge
  assign w_to_hit = (r_state != S_IDLE) && !w_fall &&
                    (r_to == TW'(TIMEOUT_CYC - 2));

  always_ff @(posedge clk_100m or posedge rst) begin
    if (rst) begin
      r_clk_d <= 1'b1;
      r_state <= S_IDLE;
      r_bit   <= '0;
      r_sr    <= '0;
      r_par   <= 1'b0;
      r_to    <= '0;
      r_kbd   <= '0;
      r_byte  <= '0;
      r_valid <= 1'b0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
`ifdef PS2_BREAK_FILTER_EN
      r_brk   <= 1'b0;
`endif
    end else begin
      r_clk_d <= r_flt[0];
      r_valid <= 1'b0;
      r_perr  <= 1'b0;
      r_ferr  <= 1'b0;
      if (w_fall || r_state == S_IDLE) r_to <= '0;
      else r_to <= r_to + TW'(1);
      if (w_to_hit) begin
        r_ferr  <= 1'b1;
        r_state <= S_IDLE;
      end else if (w_fall) begin
        unique case (r_state)
          S_IDLE: begin
            if (!w_din) begin
              r_state <= S_DATA;
              r_bit   <= '0;
            end
          end
          S_DATA: begin
            r_sr  <= {w_din, r_sr[7:1]};
            r_bit <= r_bit + 3'd1;
            if (r_bit == 3'd7) r_state <= S_PARITY;
          end
          S_PARITY: begin
            r_par   <= w_din;
            r_state <= S_STOP;
          end
          S_STOP: begin
            r_state <= S_IDLE;
            if (!w_din) begin
              r_ferr <= 1'b1;
            end else if (!w_par_ok) begin
              r_perr <= 1'b1;
            end else begin
              r_valid <= 1'b1;
              r_byte  <= r_sr;
`ifdef PS2_BREAK_FILTER_EN
              if (r_brk) r_brk <= 1'b0;
              else if (r_sr == 8'hF0) r_brk <= 1'b1;
              else r_kbd <= {r_kbd[23:0], r_sr};
`else
              r_kbd <= {r_kbd[23:0], r_sr};
`endif
            end
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign kbd        = r_kbd;
  assign byte_out   = r_byte;
  assign byte_valid = r_valid;
  assign parity_err = r_perr;
  assign frame_err  = r_ferr;
endmodule

// File: tb/tb_ps2_kbd_capture.sv
// Randomised frame bench for ps2_kbd_capture with a frame-level outcome model.
// Expectations are queued per frame and checked by one compare process.
module tb_ps2_kbd_capture;
  localparam int FL   = 8;
  localparam int TO   = 200;
  localparam int HALF = 20;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ps2_clk = 1'b1;
  logic        ps2_data = 1'b1;
  logic [31:0] kbd;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic        parity_err;
  logic        frame_err;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_fall = 0;
  int n_valid = 0, n_perr = 0, n_ferr = 0;
  int last_valid_cyc = -1, last_ferr_cyc = -1;
  int lat = 0;
  bit lat_set = 0;
  int exp_q[$];
  logic [31:0] m_kbd;
  logic [7:0]  m_byte;
  bit          m_brk;

  ps2_kbd_capture #(.FILTER_LEN(FL), .TIMEOUT_CYC(TO)) dut (
    .clk_100m(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
    .kbd(kbd), .byte_out(byte_out), .byte_valid(byte_valid),
    .parity_err(parity_err), .frame_err(frame_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  always @(negedge clk) begin
    int kind, e, s;
    logic [7:0] b;
    if (rst) begin
      m_kbd = '0;
      m_byte = '0;
      m_brk = 0;
      chk("rst_outputs", {byte_valid, parity_err, frame_err}, 0);
    end else begin
      s = int'(byte_valid) + int'(parity_err) + int'(frame_err);
      chk("pulse_onehot", (s <= 1) ? 1 : 0, 1);
      if (s != 0) begin
        kind = byte_valid ? 1 : (parity_err ? 2 : 3);
        if (kind == 1) begin n_valid++; last_valid_cyc = cyc; end
        if (kind == 2) n_perr++;
        if (kind == 3) begin n_ferr++; last_ferr_cyc = cyc; end
        if (exp_q.size() == 0) begin
          chk("unexpected_pulse", kind, 0);
        end else begin
          e = exp_q.pop_front();
          chk("pulse_kind", kind, e >> 8);
          if ((e >> 8) == 1) begin
            b = e[7:0];
            m_byte = b;
`ifdef PS2_BREAK_FILTER_EN
            if (m_brk) m_brk = 0;
            else if (b == 8'hF0) m_brk = 1;
            else m_kbd = {m_kbd[23:0], b};
`else
            m_kbd = {m_kbd[23:0], b};
`endif
          end
        end
      end
    end
    chk("kbd", kbd, m_kbd);
    chk("byte_out", {24'd0, byte_out}, {24'd0, m_byte});
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [7:0] b, input bit par_ok, input bit stop,
                      input int nfall, input bit glitch);
    logic [10:0] fr;
    logic p;
    p = ~^b;
    if (!par_ok) p = ~p;
    fr = {stop, p, b, 1'b0};
    for (int i = 0; i < nfall; i++) begin
      ps2_data = fr[i];
      if (glitch) begin
        tick(12); ps2_clk = 1'b0; tick(3); ps2_clk = 1'b1; tick(HALF - 15);
      end else begin
        tick(HALF);
      end
      ps2_clk = 1'b0;
      last_fall = cyc;
      if (glitch) begin
        tick(12); ps2_clk = 1'b1; tick(3); ps2_clk = 1'b0; tick(HALF - 15);
      end else begin
        tick(HALF);
      end
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    tick(HALF);
  endtask

  task automatic frame(input logic [7:0] b, input bit par_ok, input bit stop,
                       input bit glitch);
    int kind, v0;
    kind = !stop ? 3 : (par_ok ? 1 : 2);
    exp_q.push_back((kind << 8) | int'(b));
    v0 = n_valid;
    send(b, par_ok, stop, 11, glitch);
    if (kind == 1 && n_valid == v0 + 1) begin
      if (!lat_set) begin
        lat = last_valid_cyc - last_fall;
        lat_set = 1;
      end else begin
        chk("valid_latency", last_valid_cyc - last_fall, lat);
      end
    end
    tick(40);
  endtask

  initial begin
    int v0, p0, f0, d4, r;
    logic [7:0] rb;
    #1 rst = 1'b1;
    tick(5);
    chk("reset_kbd", kbd, 32'h0);
    chk("reset_byte", {24'd0, byte_out}, 32'h0);
    rst = 1'b0;
    tick(10);

    v0 = n_valid;
    frame(8'h1C, 1, 1, 0);
    frame(8'h32, 1, 1, 0);
    frame(8'h21, 1, 1, 0);
    frame(8'h23, 1, 1, 0);
    chk("four_bytes_kbd", kbd, 32'h1C322123);
    chk("four_valid_pulses", n_valid - v0, 4);
    chk("last_byte_out", {24'd0, byte_out}, 32'h23);

    v0 = n_valid; p0 = n_perr;
    frame(8'h1C, 0, 1, 0);
    chk("parity_err_count", n_perr - p0, 1);
    chk("parity_no_valid", n_valid - v0, 0);
    chk("parity_kbd_held", kbd, 32'h1C322123);

    p0 = n_perr; f0 = n_ferr;
    frame(8'h1C, 1, 0, 0);
    chk("stop_frame_err", n_ferr - f0, 1);
    chk("stop_no_parity", n_perr - p0, 0);
    frame(8'h2B, 1, 1, 0);
    chk("after_stop_kbd", kbd, 32'h3221232B);

    f0 = n_ferr;
    exp_q.push_back(3 << 8);
    send(8'h1C, 1, 1, 5, 0);
    d4 = last_fall;
    for (int i = 0; i < TO + 200 && n_ferr == f0; i++) tick(1);
    chk("timeout_pulse", n_ferr - f0, 1);
    chk("timeout_cycle", last_ferr_cyc, d4 + lat - 1 + TO);
    tick(20);
    frame(8'h5A, 1, 1, 0);
    chk("after_timeout_kbd", kbd, 32'h21232B5A);

    frame(8'h3C, 1, 1, 1);
    chk("glitch_kbd", kbd, 32'h232B5A3C);

    send(8'h77, 1, 1, 5, 0);
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(TO + 50);
    chk("midframe_rst_kbd", kbd, 32'h0);

`ifdef PS2_BREAK_FILTER_EN
    v0 = n_valid;
    frame(8'h1C, 1, 1, 0);
    frame(8'hF0, 1, 1, 0);
    frame(8'h1C, 1, 1, 0);
    chk("break_kbd", kbd, 32'h0000001C);
    chk("break_valid_pulses", n_valid - v0, 3);
`else
    frame(8'hF0, 1, 1, 0);
    chk("f0_shifted", {24'd0, kbd[7:0]}, 32'hF0);
`endif

    for (int k = 0; k < 24; k++) begin
      r = $urandom_range(0, 9);
      rb = (r == 2) ? 8'hF0 : 8'($urandom);
      frame(rb, r != 1, r != 0, r >= 8);
    end

    chk("queue_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
